// File: rtl/fifo_uart_pkg.sv
// Shared types and helpers for the FIFO-fed UART transmitter.
package fifo_uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  // Parity bit for a data byte; odd=1 selects odd parity.
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period down-counter: bit_tick marks the last clk of each UART bit.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic bit_tick
);

  localparam int W = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] RELOAD = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] count;

  // Auto-reloads on every tick so consecutive bits are back-to-back.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (restart || count == '0) begin
      count <= RELOAD;
    end else begin
      count <= count - 1'b1;
    end
  end

  assign bit_tick = (count == '0);

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from the FIFO read port and sends each as a UART frame on tx.
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 fifo_empty,
  input  logic [DATA_BITS-1:0] fifo_rd_data,
  output logic                 fifo_rd,
  output logic                 tx,
  output logic                 busy,
  output logic                 frame_done
);

  localparam logic LAST_STOP_IDX = 1'(STOP_BITS - 1);
  localparam logic ODD           = (PARITY_ODD != 0);

  state_t               state, state_next;
  logic [DATA_BITS-1:0] shift, shift_next;
  logic [2:0]           bit_idx, bit_idx_next;
  logic                 stop_idx, stop_idx_next;
  logic                 tx_next;
  logic                 restart;
  logic                 bit_tick;
  logic                 last_stop;

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .restart  (restart),
    .bit_tick (bit_tick)
  );

  assign last_stop  = (state == STOP) && bit_tick && (stop_idx == LAST_STOP_IDX);
  assign fifo_rd    = ((state == IDLE) || last_stop) && enable && !fifo_empty && !reset;
  assign frame_done = last_stop && !reset;
  assign busy       = (state != IDLE);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_next    = state;
    shift_next    = shift;
    bit_idx_next  = bit_idx;
    stop_idx_next = stop_idx;
    restart       = 1'b0;

    case (state)
      IDLE: ;
      START: if (bit_tick) state_next = DATA;
      DATA: begin
        if (bit_tick) begin
          // Rotate rather than shift: after 8 bits the byte is intact for parity.
          shift_next   = {shift[0], shift[DATA_BITS-1:1]};
          bit_idx_next = bit_idx + 3'd1;
          if (bit_idx == 3'(DATA_BITS - 1)) state_next = (PARITY_EN != 0) ? PARITY : STOP;
        end
      end
      PARITY: if (bit_tick) state_next = STOP;
      STOP: begin
        if (bit_tick) begin
          if (stop_idx == LAST_STOP_IDX) begin
            stop_idx_next = 1'b0;
            state_next    = IDLE;
          end else begin
            stop_idx_next = stop_idx + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // A pop (from IDLE or the final stop cycle) always launches a fresh frame.
    if (fifo_rd) begin
      shift_next    = fifo_rd_data;
      state_next    = START;
      bit_idx_next  = 3'd0;
      stop_idx_next = 1'b0;
      restart       = 1'b1;
    end

    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      PARITY:  tx_next = parity_bit(shift_next, ODD);
      default: tx_next = 1'b1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      shift    <= '0;
      bit_idx  <= 3'd0;
      stop_idx <= 1'b0;
      tx       <= 1'b1;
    end else begin
      state    <= state_next;
      shift    <= shift_next;
      bit_idx  <= bit_idx_next;
      stop_idx <= stop_idx_next;
      tx       <= tx_next;
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboard bench: three DUT configurations, a FIFO model and per-DUT frame monitors.
module tb_fifo_uart_tx;

  localparam int CPB = 4;

  typedef struct {
    int    inst;
    string pat;    // expected tx bit per UART bit, in time order
    bit    abort;  // frame is expected to be cut short by reset
  } exp_t;

  logic       clk;
  logic       reset;
  logic [2:0] enable;
  logic [2:0] fifo_empty;
  logic [7:0] fifo_data;
  logic [2:0] fifo_rd;
  logic [2:0] tx;
  logic [2:0] busy;
  logic [2:0] frame_done;

  exp_t       sb[$];
  logic [7:0] fifo_q[$];
  int         pop_cyc[$];
  int         sel;
  int         cyc;
  int         n_cmp;
  int         n_fail;
  int         pop_cnt[3];
  int         fd_cnt[3];
  int         busy_cnt[3];
  int         low_cnt[3];

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut_a (
    .clk(clk), .reset(reset), .enable(enable[0]), .fifo_empty(fifo_empty[0]),
    .fifo_rd_data(fifo_data), .fifo_rd(fifo_rd[0]), .tx(tx[0]), .busy(busy[0]),
    .frame_done(frame_done[0]));

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut_b (
    .clk(clk), .reset(reset), .enable(enable[1]), .fifo_empty(fifo_empty[1]),
    .fifo_rd_data(fifo_data), .fifo_rd(fifo_rd[1]), .tx(tx[1]), .busy(busy[1]),
    .frame_done(frame_done[1]));

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) dut_c (
    .clk(clk), .reset(reset), .enable(enable[2]), .fifo_empty(fifo_empty[2]),
    .fifo_rd_data(fifo_data), .fifo_rd(fifo_rd[2]), .tx(tx[2]), .busy(busy[2]),
    .frame_done(frame_done[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic void refresh();
    fifo_data = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
    for (int i = 0; i < 3; i++) fifo_empty[i] = !(i == sel && fifo_q.size() > 0);
  endfunction

  function automatic void clear_counts();
    for (int i = 0; i < 3; i++) begin
      pop_cnt[i]  = 0;
      fd_cnt[i]   = 0;
      busy_cnt[i] = 0;
      low_cnt[i]  = 0;
    end
    pop_cyc.delete();
  endfunction

  function automatic void push_exp(input int inst, input string pat, input bit abort);
    exp_t e;
    e.inst  = inst;
    e.pat   = pat;
    e.abort = abort;
    sb.push_back(e);
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // FIFO model and activity counters: observe at negedge, pop just after the edge.
  initial begin
    bit do_pop;
    forever begin
      @(negedge clk);
      do_pop = 1'b0;
      for (int i = 0; i < 3; i++) begin
        pop_cnt[i]  += int'(fifo_rd[i]);
        fd_cnt[i]   += int'(frame_done[i]);
        busy_cnt[i] += int'(busy[i]);
        low_cnt[i]  += int'(!tx[i]);
      end
      if (fifo_rd[sel]) begin
        do_pop = 1'b1;
        pop_cyc.push_back(cyc);
      end
      @(posedge clk);
      #1;
      if (do_pop && fifo_q.size() > 0) void'(fifo_q.pop_front());
      refresh();
    end
  end

  // Frame monitor: decodes each frame on tx[i] and compares against the scoreboard head.
  task automatic monitor(input int i);
    exp_t e;
    int   bit_errs;
    int   fd_errs;
    int   busy_errs;
    bit   aborted;
    logic exp_bit;
    forever begin
      @(negedge clk);
      if (tx[i] !== 1'b0 || reset) continue;
      if (sb.size() == 0) begin
        check($sformatf("unexpected_frame_%0d", i), 1, 0);
        continue;
      end
      e = sb.pop_front();
      check("frame_inst", i, e.inst);
      bit_errs  = 0;
      fd_errs   = 0;
      busy_errs = 0;
      aborted   = 1'b0;
      for (int b = 0; b < e.pat.len() && !aborted; b++) begin
        for (int c = 0; c < CPB && !aborted; c++) begin
          if (!(b == 0 && c == 0)) @(negedge clk);
          if (reset) begin
            aborted = 1'b1;
          end else begin
            exp_bit = (e.pat.substr(b, b) == "1");
            if (tx[i] !== exp_bit) bit_errs++;
            if (frame_done[i] !== (b == e.pat.len() - 1 && c == CPB - 1)) fd_errs++;
            if (busy[i] !== 1'b1) busy_errs++;
          end
        end
      end
      check($sformatf("frame_abort_%0d", i), int'(aborted), int'(e.abort));
      if (!aborted) begin
        check($sformatf("frame_bits_%0d", i), bit_errs, 0);
        check($sformatf("frame_done_timing_%0d", i), fd_errs, 0);
        check($sformatf("frame_busy_%0d", i), busy_errs, 0);
      end
    end
  endtask

  initial begin
    fork
      monitor(0);
      monitor(1);
      monitor(2);
    join_none
  end

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    reset  = 1'b1;
    enable = 3'b001;
    sel    = 0;
    clear_counts();
    // 0xA5 LSB first: 1,0,1,0,0,1,0,1
    fifo_q.push_back(8'hA5);
    push_exp(0, "0101001011", 1'b0);
    refresh();

    // Reset state, with data present and enabled: nothing may pop.
    step(3);
    check("reset_tx", int'(tx), 7);
    check("reset_busy", int'(busy), 0);
    check("reset_frame_done", int'(frame_done), 0);
    check("reset_fifo_rd", int'(fifo_rd), 0);
    check("reset_no_pop", pop_cnt[0], 0);

    // Single frame, 40 cycles.
    reset = 1'b0;
    clear_counts();
    step(50);
    check("single_pops", pop_cnt[0], 1);
    check("single_frame_done", fd_cnt[0], 1);
    check("single_busy_cycles", busy_cnt[0], 40);

    // Back-to-back 0x00 then 0xFF.
    clear_counts();
    fifo_q.push_back(8'h00);
    fifo_q.push_back(8'hFF);
    push_exp(0, "0000000001", 1'b0);
    push_exp(0, "0111111111", 1'b0);
    refresh();
    step(90);
    check("b2b_pops", pop_cyc.size(), 2);
    if (pop_cyc.size() == 2) check("b2b_spacing", pop_cyc[1] - pop_cyc[0], 40);
    check("b2b_busy_cycles", busy_cnt[0], 80);
    check("b2b_frame_done", fd_cnt[0], 2);

    // Empty FIFO, enabled.
    clear_counts();
    step(100);
    check("empty_pops", pop_cnt[0], 0);
    check("empty_busy", busy_cnt[0], 0);
    check("empty_tx_low", low_cnt[0], 0);

    // Data present, disabled.
    enable = 3'b000;
    fifo_q.push_back(8'h5A);
    refresh();
    clear_counts();
    step(50);
    check("disabled_pops", pop_cnt[0], 0);
    check("disabled_busy", busy_cnt[0], 0);
    check("disabled_tx_low", low_cnt[0], 0);

    // Reset during DATA bit 3 of the 0x5A frame.
    push_exp(0, "0010110101", 1'b1);
    clear_counts();
    enable = 3'b001;
    step(18);
    reset = 1'b1;
    step(1);
    check("midreset_tx", int'(tx[0]), 1);
    check("midreset_busy", int'(busy[0]), 0);
    check("midreset_frame_done", fd_cnt[0], 0);
    check("midreset_pops", pop_cnt[0], 1);
    reset = 1'b0;
    // 0xC3 LSB first: 1,1,0,0,0,0,1,1
    fifo_q.push_back(8'hC3);
    push_exp(0, "0110000111", 1'b0);
    refresh();
    clear_counts();
    step(50);
    check("postreset_pops", pop_cnt[0], 1);
    check("postreset_frame_done", fd_cnt[0], 1);
    check("postreset_busy_cycles", busy_cnt[0], 40);

    // Even parity, 0xA5 has four ones -> parity 0, 44 cycles.
    sel    = 1;
    enable = 3'b010;
    fifo_q.push_back(8'hA5);
    push_exp(1, "01010010101", 1'b0);
    refresh();
    clear_counts();
    step(55);
    check("even_pops", pop_cnt[1], 1);
    check("even_busy_cycles", busy_cnt[1], 44);
    check("even_frame_done", fd_cnt[1], 1);

    // Odd parity -> 1, two stop bits (8 cycles), enable dropped during DATA.
    sel    = 2;
    enable = 3'b100;
    fifo_q.push_back(8'hA5);
    fifo_q.push_back(8'h81);
    push_exp(2, "010100101111", 1'b0);
    refresh();
    clear_counts();
    step(10);
    enable = 3'b000;
    step(60);
    check("odd_pops", pop_cnt[2], 1);
    check("odd_busy_cycles", busy_cnt[2], 48);
    check("odd_frame_done", fd_cnt[2], 1);
    check("odd_fifo_left", fifo_q.size(), 1);
    check("odd_other_pops", pop_cnt[0] + pop_cnt[1], 0);

    check("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
